// File: rtl/ws2812_strand_driver_if.sv
// Colour request channel between the WS2812 strand driver (master) and the LED output mux (slave).
interface ws2812_strand_driver_if #(
    parameter int NUM_LEDS    = 64,
    parameter int COLOR_WIDTH = 8
);
    localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    logic [COLOR_WIDTH-1:0] green_in;
    logic [COLOR_WIDTH-1:0] red_in;
    logic [COLOR_WIDTH-1:0] blue_in;
    logic                   color_valid_in;
    logic                   next_led_request_out;
    logic [IDX_W-1:0]       next_led_index_out;

    // Handshake: next_led_request_out is a one-cycle pulse with next_led_index_out stable.
    // The colour transfers on the first cycle after that pulse in which color_valid_in is
    // high; valid during the request cycle itself or while bits are being shifted is ignored.
    modport master (
        input  green_in,
        input  red_in,
        input  blue_in,
        input  color_valid_in,
        output next_led_request_out,
        output next_led_index_out
    );

    modport slave (
        output green_in,
        output red_in,
        output blue_in,
        output color_valid_in,
        input  next_led_request_out,
        input  next_led_index_out
    );
endinterface

// File: rtl/ws2812_strand_driver.sv
// WS2812 single-wire strand driver: requests each LED colour by index and shifts GRB MSB-first.
// Optional macro WS2812_STRAND_DRIVER_TIMEOUT_EN adds WAIT_TIMEOUT and timeout_err_out.
module ws2812_strand_driver #(
    parameter int NUM_LEDS     = 64,
    parameter int COLOR_WIDTH  = 8,
    parameter int T0H          = 40,
    parameter int T0L          = 85,
    parameter int T1H          = 80,
    parameter int T1L          = 45,
    parameter int RESET_CYCLES = 8000
`ifdef WS2812_STRAND_DRIVER_TIMEOUT_EN
    ,
    parameter int WAIT_TIMEOUT = 1000
`endif
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    ws2812_strand_driver_if.master        led,
    output logic                          strand_out,
    output logic                          frame_done_out,
    output logic                          busy_out,
    output logic [2:0]                    state_dbg_out
`ifdef WS2812_STRAND_DRIVER_TIMEOUT_EN
    ,
    output logic                          timeout_err_out
`endif
);
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int IDX_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int SR_W     = 3 * COLOR_WIDTH;
    localparam int BIT_W    = (SR_W > 1) ? $clog2(SR_W) : 1;
    localparam int MAX_BASE = max2(max2(max2(T0H, T0L), max2(T1H, T1L)), RESET_CYCLES);
`ifdef WS2812_STRAND_DRIVER_TIMEOUT_EN
    localparam int MAX_T    = max2(MAX_BASE, WAIT_TIMEOUT);
`else
    localparam int MAX_T    = MAX_BASE;
`endif
    localparam int CNT_W    = $clog2(MAX_T + 1);

    localparam logic [2:0] ST_LATCH   = 3'd0;
    localparam logic [2:0] ST_REQUEST = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_HIGH    = 3'd3;
    localparam logic [2:0] ST_LOW     = 3'd4;

    // Phase counters run 0..N-1, so each phase ends on the value N-1.
    localparam logic [CNT_W-1:0] T0H_END   = CNT_W'(T0H - 1);
    localparam logic [CNT_W-1:0] T0L_END   = CNT_W'(T0L - 1);
    localparam logic [CNT_W-1:0] T1H_END   = CNT_W'(T1H - 1);
    localparam logic [CNT_W-1:0] T1L_END   = CNT_W'(T1L - 1);
    localparam logic [CNT_W-1:0] LATCH_END = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(SR_W - 1);
    localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_LEDS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [SR_W-1:0]  shreg;
    logic [BIT_W-1:0] bit_cnt;
    logic [IDX_W-1:0] idx;

    logic             cur_bit;
    logic [CNT_W-1:0] high_end;
    logic [CNT_W-1:0] low_end;
    logic             high_done;
    logic             low_done;
    logic             last_bit;
    logic             last_led;

    // Both phases of a bit take their length from the MSB, which only shifts once the low phase ends.
    always_comb begin
        cur_bit   = shreg[SR_W-1];
        high_end  = cur_bit ? T1H_END : T0H_END;
        low_end   = cur_bit ? T1L_END : T0L_END;
        high_done = (cnt == high_end);
        low_done  = (cnt == low_end);
        last_bit  = (bit_cnt == LAST_BIT);
        last_led  = (idx == LAST_IDX);
    end

`ifdef WS2812_STRAND_DRIVER_TIMEOUT_EN
    localparam logic [CNT_W-1:0] WAIT_END = CNT_W'(WAIT_TIMEOUT - 1);
    logic wait_expired;

    always_comb begin
        wait_expired = (state == ST_WAIT) && !led.color_valid_in && (cnt == WAIT_END);
    end

    assign timeout_err_out = wait_expired;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state   <= ST_LATCH;
            cnt     <= '0;
            shreg   <= '0;
            bit_cnt <= '0;
            idx     <= '0;
        end else begin
            case (state)
                ST_LATCH: begin
                    if (cnt == LATCH_END) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= ST_REQUEST;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_REQUEST: begin
                    cnt   <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (led.color_valid_in) begin
                        shreg   <= {led.green_in, led.red_in, led.blue_in};
                        bit_cnt <= '0;
                        cnt     <= '0;
                        state   <= ST_HIGH;
`ifdef WS2812_STRAND_DRIVER_TIMEOUT_EN
                    end else if (wait_expired) begin
                        // Upstream never answered: send black so the strand stays in step.
                        shreg   <= '0;
                        bit_cnt <= '0;
                        cnt     <= '0;
                        state   <= ST_HIGH;
                    end else begin
                        cnt <= cnt + CNT_ONE;
`endif
                    end
                end
                ST_HIGH: begin
                    if (high_done) begin
                        cnt   <= '0;
                        state <= ST_LOW;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_LOW: begin
                    if (low_done) begin
                        cnt <= '0;
                        if (!last_bit) begin
                            shreg   <= shreg << 1;
                            bit_cnt <= bit_cnt + BIT_ONE;
                            state   <= ST_HIGH;
                        end else if (!last_led) begin
                            idx   <= idx + IDX_ONE;
                            state <= ST_REQUEST;
                        end else begin
                            state <= ST_LATCH;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_LATCH;
                end
            endcase
        end
    end

    // The line is a pure decode of the state, so a reset drops it on the very next edge.
    assign strand_out               = (state == ST_HIGH);
    assign led.next_led_request_out = (state == ST_REQUEST);
    assign led.next_led_index_out   = idx;
    assign frame_done_out           = (state == ST_LOW) && low_done && last_bit && last_led;
    assign busy_out                 = (state != ST_LATCH);
    assign state_dbg_out            = state;
endmodule
